// File: rtl/mem_arb_pkg.sv
// Shared encodings for the femtoRV32 unified-memory arbiter: FSM states, owners,
// load/store funct3 codes and the alignment check used by the misalign option.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = F3_LB;
    localparam logic [2:0] F3_SH  = F3_LH;
    localparam logic [2:0] F3_SW  = F3_LW;

    // Fetches are always word accesses; data size comes from funct3[1:0].
    function automatic logic is_misaligned(input owner_t own, input logic [2:0] f3,
                                           input logic [7:0] addr);
        logic w_mis;
        w_mis = 1'b0;
        if (own == OWN_FETCH) begin
            w_mis = (addr[1:0] != 2'b00);
        end else begin
            case (f3[1:0])
                2'b10:   w_mis = (addr[1:0] != 2'b00);
                2'b01:   w_mis = addr[0];
                default: w_mis = 1'b0;
            endcase
        end
        return w_mis;
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Fetch/data priority select with a saturating starvation counter that forces
// a pending fetch through after STARVE_MAX consecutive data grants.
module mem_arb_grant #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_arb_en,
    input  logic i_if_valid,
    input  logic i_d_valid,
    output logic o_grant_if,
    output logic o_grant_d
);
    import mem_arb_pkg::*;

    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0] r_starve_cnt;
    logic       w_starved;

    assign w_starved = (r_starve_cnt == LP_STARVE_MAX);

    always_comb begin
        o_grant_if = 1'b0;
        o_grant_d  = 1'b0;
        if (i_arb_en) begin
            if (i_if_valid && (!i_d_valid || w_starved)) begin
                o_grant_if = 1'b1;
            end else if (i_d_valid) begin
                o_grant_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (!i_if_valid || o_grant_if) begin
            r_starve_cnt <= 4'd0;
        end else if (o_grant_d && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/load-store arbiter and one-shot sequencer for the single-port Mem.
// Define MEM_ARB_MISALIGN_EN to suppress misaligned accesses and flag *_rsp_err.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [7:0]  if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [7:0]  d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    arb_state_t  r_state, w_state_next;
    owner_t      r_owner;
    logic [7:0]  r_addr;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_wdata;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;
    logic        w_arb_en, w_grant_if, w_grant_d, w_access, w_misalign;

    assign w_arb_en = (r_state == ST_IDLE) || (r_state == ST_RESP);
    assign w_access = (r_state == ST_ACCESS);

    mem_arb_grant #(.STARVE_MAX(STARVE_MAX)) u_grant (
        .clk        (clk),
        .rst        (rst),
        .i_arb_en   (w_arb_en),
        .i_if_valid (if_req_valid),
        .i_d_valid  (d_req_valid),
        .o_grant_if (w_grant_if),
        .o_grant_d  (w_grant_d)
    );

`ifdef MEM_ARB_MISALIGN_EN
    assign w_misalign = is_misaligned(r_owner, r_funct3, r_addr);
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_grant_if || w_grant_d) w_state_next = ST_ACCESS;
            ST_ACCESS: w_state_next = ST_RESP;
            ST_RESP:   w_state_next = (w_grant_if || w_grant_d) ? ST_ACCESS : ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner  <= OWN_FETCH;
            r_addr   <= 8'd0;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_wdata  <= 32'd0;
        end else if (w_grant_d) begin
            r_owner  <= OWN_DATA;
            r_addr   <= d_addr;
            r_we     <= d_we;
            r_funct3 <= d_funct3;
            r_wdata  <= d_wdata;
        end else if (w_grant_if) begin
            r_owner  <= OWN_FETCH;
            r_addr   <= if_addr;
            r_we     <= 1'b0;
            r_funct3 <= F3_LW;
            r_wdata  <= 32'd0;
        end
    end

    // Stores and suppressed accesses report zero data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_data <= 32'd0;
            r_rsp_err  <= 1'b0;
        end else if (w_access) begin
            r_rsp_data <= (w_misalign || (r_owner == OWN_DATA && r_we)) ? 32'd0 : mem_rdata;
            r_rsp_err  <= w_misalign;
        end
    end

    always_comb begin
        if_req_ready = w_grant_if;
        d_req_ready  = w_grant_d;
        if_rsp_valid = 1'b0;
        if_rsp_data  = 32'd0;
        if_rsp_err   = 1'b0;
        d_rsp_valid  = 1'b0;
        d_rsp_data   = 32'd0;
        d_rsp_err    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_funct3   = 3'd0;
        mem_addr     = 8'd0;
        mem_wdata    = 32'd0;
        if (r_state == ST_RESP) begin
            if (r_owner == OWN_FETCH) begin
                if_rsp_valid = 1'b1;
                if_rsp_data  = r_rsp_data;
                if_rsp_err   = r_rsp_err;
            end else begin
                d_rsp_valid  = 1'b1;
                d_rsp_data   = r_rsp_data;
                d_rsp_err    = r_rsp_err;
            end
        end
        if (w_access) begin
            mem_read   = (r_owner == OWN_DATA) && !r_we && !w_misalign;
            mem_write  = (r_owner == OWN_DATA) && r_we && !w_misalign;
            mem_funct3 = r_funct3;
            mem_addr   = r_addr;
            mem_wdata  = r_wdata;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the unified single-port byte-addressed `Mem` of the femtoRV32 core. It shares that memory between instruction fetch and the load/store unit. Each accepted request is registered and driven onto the memory for exactly one cycle. The result comes back as a single-cycle response pulse. Data accesses have priority, and a starvation counter bounds how long a pending fetch can be blocked.

## Interface
- `STARVE_MAX`, default 4: consecutive data grants allowed while a fetch is pending before fetch is forced (1..15).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `if_req_valid`  in  1  fetch request.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_addr`  in  8  fetch byte address.
- `if_rsp_valid`  out  1  fetch response pulse.
- `if_rsp_data`  out  32  instruction word.
- `if_rsp_err`  out  1  fetch error (see Configuration).
- `d_req_valid`  in  1  data request.
- `d_req_ready`  out  1  data request accepted this cycle.
- `d_we`  in  1  1 = store, 0 = load.
- `d_funct3`  in  3  LB/LH/LW/LBU/LHU/SB/SH/SW encoding.
- `d_addr`  in  8  data byte address.
- `d_wdata`  in  32  store data.
- `d_rsp_valid`  out  1  data response pulse (load and store).
- `d_rsp_data`  out  32  load result; 0 for stores.
- `d_rsp_err`  out  1  data error.
- `mem_read`, `mem_write`  out  1 each  to `Mem` `MemRead`/`MemWrite`.
- `mem_funct3`  out  3  to `Mem` `funct3`.
- `mem_addr`  out  8  to `Mem` `addr`.
- `mem_wdata`  out  32  to `Mem` `data_in`.
- `mem_rdata`  in  32  from `Mem` `data_out` (combinational).

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - Grant if any request is valid: assert the winner's `*_req_ready`.
  - Latch owner, addr, we, funct3 and wdata into the request register, then go to ACCESS.
  - Fetch latches funct3 = 010, we = 0, wdata = 0.
- **ACCESS**
  - Drive `mem_addr`, `mem_funct3` and `mem_wdata` from the request register.
  - Fetch: `mem_read` = 0, `mem_write` = 0 (memory returns a raw word).
  - Load: `mem_read` = 1.
  - Store: `mem_write` = 1.
  - Capture `mem_rdata` into the response register at the cycle's end; go to RESP.
- **RESP**
  - Pulse the owner's `*_rsp_valid` with the response register.
  - Arbitration is evaluated exactly as in IDLE. On a grant, go to ACCESS; otherwise go to IDLE.
- Outside ACCESS: `mem_read` = `mem_write` = 0, `mem_addr`/`mem_funct3`/`mem_wdata` = 0.
- Arbitration when both requests are valid: data wins, unless `starve_cnt` == `STARVE_MAX`, in which case fetch wins.
- `starve_cnt` (4 bits):
  - +1 on a data grant while `if_req_valid` = 1.
  - Cleared on a fetch grant, or in any cycle with `if_req_valid` = 0.
  - Saturates at `STARVE_MAX`.
- Requesters hold `valid` and payload stable until `ready`. Responses have no backpressure.
- Store response: `d_rsp_data` = 0. `Mem` addresses wrap modulo 256.

## Timing
- Request accepted at edge T → memory access in cycle T+1 → `rsp_valid` high in cycle T+2 only.
- Peak throughput is one access every 2 cycles, because a grant is possible in the RESP cycle.
- Store write lands at the rising edge ending ACCESS.
- A load that follows a store to the same address sees the new data.
- `*_req_ready` is combinational from state, valids and `starve_cnt`. Never assert both in the same cycle.
- Reset values:
  - State = IDLE; all `*_ready`, `*_rsp_valid`, `*_rsp_err`, `mem_*` outputs = 0.
  - `*_rsp_data` = 0; `starve_cnt` = 0.
- Reset during ACCESS: `mem_write` drops immediately, so no write is performed. The in-flight response is discarded.

## Configuration
- `MEM_ARB_MISALIGN_EN` defined:
  - Misaligned accesses are: LW/SW with addr[1:0] ≠ 0; LH/LHU/SH with addr[0] ≠ 0; fetch with addr[1:0] ≠ 0.
  - For these, ACCESS keeps `mem_read` = `mem_write` = 0, the response data is 0, and `*_rsp_err` = 1 on the response pulse.
  - Timing is unchanged.
- Not defined: no check is made, `*_rsp_err` is tied 0, and misaligned accesses proceed with `Mem`'s byte-assembly semantics.

## Structure
- Shared defines/package `mem_arb_pkg`:
  - FSM state encoding (IDLE = 0, ACCESS = 1, RESP = 2).
  - Owner encoding (FETCH = 0, DATA = 1).
  - funct3 constants F3_LB/LH/LW/LBU/LHU, and SB/SH/SW reusing the same codes.
- One sub-module, `mem_arb_grant`: combinational priority select plus the `starve_cnt` register.
- Top-level `mem_arbiter` holds the FSM, request/response registers and the misalign check.

## Test plan
- Fetch only: `if_addr` = 0x04 with memory word 0x04002083 → ready at T, `if_rsp_data` = 0x04002083 at T+2, `if_rsp_err` = 0.
- SW then LW: SW 0x12345005 @0x00, then LW @0x00 → load response = 0x12345005. Then LB @0x00 → 0x00000005, and LHU @0x02 → 0x00001234.
- Contention with `STARVE_MAX` = 4: both valid continuously → grant order D, D, D, D, I, D…; the fetch is granted at its 5th arbitration.
- Async `rst` pulse mid-ACCESS of SW 0xFFFFFFFF @0x10 → mem[0x10..0x13] unchanged, no `d_rsp_valid`, all outputs 0 until the next grant.
- `MEM_ARB_MISALIGN_EN`: LW @0x02 → `d_rsp_valid` with `d_rsp_err` = 1, data 0, `mem_read` never asserted. Without the macro: `d_rsp_err` = 0, data = {mem[5], mem[4], mem[3], mem[2]}.
